irq_vector_responder: RTL and testbench

Vectored-interrupt responder that sits on the peripheral side of the processor's interrupt acknowledge interface. It collects level interrupt requests from up to NIRQ devices and drives the CPU's virq line. When the CPU strobes for a vector, the block answers with the vector of the highest-priority pending device, returns the iack handshake, and sends a one-cycle acknowledge pulse to the device it served.

---
 rtl/irq_pkg.sv | 13 +
 rtl/irq_vector_responder_if.sv | 13 +
 rtl/irq_prio_enc.sv | 20 ++
 rtl/irq_vector_responder.sv | 111 +++++++++++
 tb/tb_irq_vector_responder.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/irq_pkg.sv
// Shared types and constants for the vectored-interrupt responder.
package irq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACK   = 2'd1,
    ST_GUARD = 2'd2
  } state_e;

  localparam int VEC_W = 16;
  localparam logic [VEC_W-1:0] SPUR_VEC = 16'o000000;

endpackage

// File: rtl/irq_vector_responder_if.sv
// CPU-side interrupt acknowledge bus: request line, vector strobe/acknowledge and vector.
interface irq_vector_responder_if;
  import irq_pkg::*;

  logic             virq;
  logic             istb;
  logic             iack;
  logic [VEC_W-1:0] ivec;

  modport master (input virq, input iack, input ivec, output istb);
  modport slave  (output virq, output iack, output ivec, input istb);

endinterface

// File: rtl/irq_prio_enc.sv
// Lowest-index-first priority encoder over the request vector.
module irq_prio_enc #(
  parameter int NIRQ  = 8,
  parameter int IDX_W = 3
) (
  input  logic [NIRQ-1:0]  req_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    idx_o   = '0;
    valid_o = |req_i;
    for (int k = NIRQ - 1; k >= 0; k--) begin
      idx_o = req_i[k] ? IDX_W'(k) : idx_o;
    end
  end

endmodule

// File: rtl/irq_vector_responder.sv
// Vectored-interrupt responder: raises virq, answers the CPU vector strobe and pulses the served device.
module irq_vector_responder
  import irq_pkg::*;
#(
  parameter int NIRQ  = 8,
  parameter int GUARD = 2
) (
  input  logic                    clk_p,
  input  logic                    rst_n,
  input  logic [NIRQ-1:0]         irq_req,
  input  logic [VEC_W*NIRQ-1:0]   irq_vec,
  output logic [NIRQ-1:0]         irq_ack,
  irq_vector_responder_if.slave   cpu
);

  localparam int IDX_W = $clog2(NIRQ);
  localparam int CNT_W = $clog2(GUARD + 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             virq_q, virq_d;
  logic             iack_q, iack_d;
  logic [VEC_W-1:0] ivec_q, ivec_d;
  logic [NIRQ-1:0]  ack_q, ack_d;

  logic [IDX_W-1:0] enc_idx_s;
  logic             enc_valid_s;
  logic [VEC_W-1:0] sel_vec_s;

  irq_prio_enc #(.NIRQ(NIRQ), .IDX_W(IDX_W)) u_prio_enc (
    .req_i   (irq_req),
    .idx_o   (enc_idx_s),
    .valid_o (enc_valid_s)
  );

  // Vector of the winning channel.
  always_comb begin
    sel_vec_s = '0;
    for (int k = 0; k < NIRQ; k++) begin
      sel_vec_s = (enc_idx_s == IDX_W'(k)) ? irq_vec[k*VEC_W +: VEC_W] : sel_vec_s;
    end
  end

  // Next state and next registered outputs; ivec_q doubles as the latched vector during ACK.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    virq_d  = 1'b0;
    iack_d  = 1'b0;
    ivec_d  = '0;
    ack_d   = '0;
    case (state_q)
      ST_IDLE: begin
        if (cpu.istb) begin
          state_d = ST_ACK;
          iack_d  = 1'b1;
          ivec_d  = enc_valid_s ? sel_vec_s : SPUR_VEC;
          ack_d   = enc_valid_s ? (NIRQ'(1) << enc_idx_s) : '0;
        end else begin
          virq_d = |irq_req;
        end
      end
      ST_ACK: begin
        if (cpu.istb) begin
          iack_d = 1'b1;
          ivec_d = ivec_q;
        end else begin
          state_d = ST_GUARD;
          cnt_d   = CNT_W'(GUARD - 1);
        end
      end
      ST_GUARD: begin
        // Keeps virq low while the served device withdraws its request.
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter and output registers.
  always_ff @(posedge clk_p or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      virq_q  <= 1'b0;
      iack_q  <= 1'b0;
      ivec_q  <= '0;
      ack_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      virq_q  <= virq_d;
      iack_q  <= iack_d;
      ivec_q  <= ivec_d;
      ack_q   <= ack_d;
    end
  end

  assign cpu.virq = virq_q;
  assign cpu.iack = iack_q;
  assign cpu.ivec = ivec_q;
  assign irq_ack  = ack_q;

endmodule

// File: tb/tb_irq_vector_responder.sv
// Randomized self-checking bench for irq_vector_responder with a rule-based expectation model.
module tb_irq_vector_responder;

  localparam int NIRQ  = 8;
  localparam int GUARD = 2;

  logic              clk_p;
  logic              rst_n;
  logic [NIRQ-1:0]   irq_req;
  logic [16*NIRQ-1:0] irq_vec;
  logic [NIRQ-1:0]   irq_ack;
  logic [15:0]       vecs [NIRQ];

  int checks;
  int errors;

  irq_vector_responder_if cpu_bus ();

  irq_vector_responder #(.NIRQ(NIRQ), .GUARD(GUARD)) dut (
    .clk_p   (clk_p),
    .rst_n   (rst_n),
    .irq_req (irq_req),
    .irq_vec (irq_vec),
    .irq_ack (irq_ack),
    .cpu     (cpu_bus)
  );

  initial clk_p = 1'b0;
  always #5 clk_p = ~clk_p;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_p);
    #1;
  endtask

  task automatic pack_vecs();
    for (int k = 0; k < NIRQ; k++) irq_vec[k*16 +: 16] = vecs[k];
  endtask

  task automatic plan_vecs();
    for (int k = 0; k < NIRQ; k++) vecs[k] = 16'o060 + 16'(4 * k);
    pack_vecs();
  endtask

  task automatic rand_vecs();
    for (int k = 0; k < NIRQ; k++) vecs[k] = 16'($urandom);
    pack_vecs();
  endtask

  // Model: highest priority device = lowest set bit, -1 when none.
  function automatic int lowest_set(input logic [NIRQ-1:0] m);
    for (int k = 0; k < NIRQ; k++) if (m[k]) return k;
    return -1;
  endfunction

  task automatic settle_idle();
    irq_req = '0;
    cpu_bus.istb = 1'b0;
    repeat (GUARD + 3) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    irq_req = '0;
    cpu_bus.istb = 1'b0;
    plan_vecs();
    #1;
    checks++;
    if ({cpu_bus.virq, cpu_bus.iack, cpu_bus.ivec, irq_ack} !== 26'd0) begin
      errors++;
      $display("FAIL reset_outputs: virq=%b iack=%b ivec=%o irq_ack=%b, expected all 0",
               cpu_bus.virq, cpu_bus.iack, cpu_bus.ivec, irq_ack);
    end
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (cpu_bus.virq !== 1'b0) begin
      errors++;
      $display("FAIL idle_virq: virq=%b expected 0", cpu_bus.virq);
    end
  endtask

  task automatic test_single();
    int k;
    plan_vecs();
    for (int it = 0; it < 3; it++) begin
      k = (it == 0) ? 3 : int'($urandom_range(0, NIRQ - 1));
      irq_req = NIRQ'(1) << k;
      tick();
      checks++;
      if (cpu_bus.virq !== 1'b1) begin
        errors++;
        $display("FAIL single_virq: ch=%0d virq=%b expected 1", k, cpu_bus.virq);
      end
      cpu_bus.istb = 1'b1;
      tick();
      checks++;
      if (cpu_bus.iack !== 1'b1 || cpu_bus.ivec !== vecs[k] || irq_ack !== (NIRQ'(1) << k)) begin
        errors++;
        $display("FAIL single_ack: ch=%0d iack=%b ivec=%o irq_ack=%b, expected 1 %o %b",
                 k, cpu_bus.iack, cpu_bus.ivec, irq_ack, vecs[k], NIRQ'(1) << k);
      end
      irq_req = '0;
      tick();
      checks++;
      if (irq_ack !== '0 || cpu_bus.iack !== 1'b1) begin
        errors++;
        $display("FAIL single_pulse_end: irq_ack=%b iack=%b, expected 0 and 1", irq_ack, cpu_bus.iack);
      end
      cpu_bus.istb = 1'b0;
      tick();
      checks++;
      if (cpu_bus.iack !== 1'b0 || cpu_bus.ivec !== 16'd0) begin
        errors++;
        $display("FAIL single_release: iack=%b ivec=%o, expected 0 0", cpu_bus.iack, cpu_bus.ivec);
      end
      settle_idle();
    end
  endtask

  task automatic test_priority();
    logic [NIRQ-1:0] mask;
    int exp;
    for (int it = 0; it < 6; it++) begin
      if (it == 0) begin
        plan_vecs();
        mask = 8'b0010_0010;
      end else begin
        rand_vecs();
        mask = NIRQ'($urandom_range(1, 255));
      end
      irq_req = mask;
      tick();
      checks++;
      if (cpu_bus.virq !== 1'b1) begin
        errors++;
        $display("FAIL prio_virq: mask=%b virq=%b expected 1", mask, cpu_bus.virq);
      end
      while (mask != '0) begin
        exp = lowest_set(mask);
        cpu_bus.istb = 1'b1;
        tick();
        checks++;
        if (cpu_bus.iack !== 1'b1 || cpu_bus.ivec !== vecs[exp] || irq_ack !== (NIRQ'(1) << exp)) begin
          errors++;
          $display("FAIL prio_ack: mask=%b iack=%b ivec=%o irq_ack=%b, expected 1 %o %b",
                   mask, cpu_bus.iack, cpu_bus.ivec, irq_ack, vecs[exp], NIRQ'(1) << exp);
        end
        mask[exp] = 1'b0;
        irq_req = mask;
        cpu_bus.istb = 1'b0;
        tick();
        checks++;
        if (cpu_bus.iack !== 1'b0 || cpu_bus.ivec !== 16'd0 || cpu_bus.virq !== 1'b0 || irq_ack !== '0) begin
          errors++;
          $display("FAIL prio_release: iack=%b ivec=%o virq=%b irq_ack=%b, expected all 0",
                   cpu_bus.iack, cpu_bus.ivec, cpu_bus.virq, irq_ack);
        end
        for (int g = 1; g <= GUARD; g++) begin
          tick();
          checks++;
          if (cpu_bus.virq !== 1'b0) begin
            errors++;
            $display("FAIL prio_guard: cycle=%0d virq=%b expected 0", g, cpu_bus.virq);
          end
        end
        tick();
        checks++;
        if (cpu_bus.virq !== (mask != '0)) begin
          errors++;
          $display("FAIL prio_rearm: mask=%b virq=%b expected %b", mask, cpu_bus.virq, mask != '0);
        end
      end
    end
    settle_idle();
  endtask

  task automatic test_spurious();
    int k;
    for (int it = 0; it < 3; it++) begin
      rand_vecs();
      k = (it == 0) ? 2 : int'($urandom_range(0, NIRQ - 1));
      irq_req = NIRQ'(1) << k;
      tick();
      irq_req = '0;
      cpu_bus.istb = 1'b1;
      tick();
      checks++;
      if (cpu_bus.iack !== 1'b1 || cpu_bus.ivec !== 16'o0 || irq_ack !== '0) begin
        errors++;
        $display("FAIL spurious: iack=%b ivec=%o irq_ack=%b, expected 1 0 0",
                 cpu_bus.iack, cpu_bus.ivec, irq_ack);
      end
      cpu_bus.istb = 1'b0;
      settle_idle();
    end
  endtask

  task automatic test_long_strobe();
    int n;
    int pulses;
    plan_vecs();
    n = 10;
    for (int it = 0; it < 2; it++) begin
      pulses = 0;
      irq_req = 8'b0000_0001;
      tick();
      cpu_bus.istb = 1'b1;
      for (int i = 0; i < n; i++) begin
        tick();
        if (irq_ack[0] === 1'b1) pulses++;
        checks++;
        if (cpu_bus.iack !== 1'b1 || cpu_bus.ivec !== 16'o060 || irq_ack !== ((i == 0) ? 8'b1 : 8'b0)) begin
          errors++;
          $display("FAIL long_hold: cycle=%0d iack=%b ivec=%o irq_ack=%b, expected 1 60 %b",
                   i, cpu_bus.iack, cpu_bus.ivec, irq_ack, (i == 0) ? 8'b1 : 8'b0);
        end
        if (i == 1) irq_req = '0;
        if (i == 3) begin
          irq_req = 8'b0000_0001;
          irq_vec[15:0] = 16'($urandom);
        end
      end
      cpu_bus.istb = 1'b0;
      tick();
      checks++;
      if (cpu_bus.iack !== 1'b0 || pulses != 1) begin
        errors++;
        $display("FAIL long_end: iack=%b pulses=%0d, expected 0 and 1", cpu_bus.iack, pulses);
      end
      pack_vecs();
      settle_idle();
      n = int'($urandom_range(3, 12));
    end
  endtask

  task automatic test_back_to_back();
    rand_vecs();
    irq_req = 8'b1000_0100;
    cpu_bus.istb = 1'b1;
    tick();
    cpu_bus.istb = 1'b0;
    tick();
    cpu_bus.istb = 1'b1;
    for (int g = 1; g <= GUARD; g++) begin
      tick();
      checks++;
      if (cpu_bus.iack !== 1'b0) begin
        errors++;
        $display("FAIL guard_istb: cycle=%0d iack=%b expected 0", g, cpu_bus.iack);
      end
    end
    tick();
    checks++;
    if (cpu_bus.iack !== 1'b1 || cpu_bus.ivec !== vecs[2] || irq_ack !== 8'b0000_0100) begin
      errors++;
      $display("FAIL guard_then_ack: iack=%b ivec=%o irq_ack=%b, expected 1 %o 00000100",
               cpu_bus.iack, cpu_bus.ivec, irq_ack, vecs[2]);
    end
    settle_idle();
  endtask

  task automatic test_reset_mid();
    logic [NIRQ-1:0] mask;
    rand_vecs();
    mask = NIRQ'($urandom_range(1, 255));
    irq_req = mask;
    tick();
    cpu_bus.istb = 1'b1;
    tick();
    checks++;
    if (cpu_bus.iack !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre_ack: iack=%b expected 1", cpu_bus.iack);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({cpu_bus.virq, cpu_bus.iack, cpu_bus.ivec, irq_ack} !== 26'd0) begin
      errors++;
      $display("FAIL rst_async: virq=%b iack=%b ivec=%o irq_ack=%b, expected all 0",
               cpu_bus.virq, cpu_bus.iack, cpu_bus.ivec, irq_ack);
    end
    cpu_bus.istb = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (cpu_bus.virq !== 1'b1 || cpu_bus.iack !== 1'b0) begin
      errors++;
      $display("FAIL rst_recover: virq=%b iack=%b, expected 1 0", cpu_bus.virq, cpu_bus.iack);
    end
    settle_idle();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single();
    test_priority();
    test_spurious();
    test_long_strobe();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
